// File: rtl/uart_rx.sv
// 8N1 serial receiver: start-edge detect, mid-bit sampling, LSB-first data, stop check.
// Optional 2-flop input synchronizer enabled by defining UART_RX_SYNC_EN.
module uart_rx #(
  parameter int CLK_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int HALF  = CLK_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             rx;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // Synchronizer resets to the idle level so reset never looks like a start edge
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], serial};
  end

  assign rx = sync_q[1];
`else
  assign rx = serial;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            if (rx) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
              cnt   <= '0;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_M1) begin
            cnt        <= '0;
            shreg[idx] <= rx;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leaving at the stop-bit centre leaves half a bit to catch a back-to-back start
          if (cnt == BIT_M1) begin
            if (rx) begin
              data  <= shreg;
              valid <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, scoreboard of expected strobes,
// plus hand sequences for framing error, glitch and mid-frame reset.
module tb_uart_rx;

  localparam int CLK_PER_BIT = 100;
  localparam int HALF        = CLK_PER_BIT / 2;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif
  localparam int LATENCY = 1 + HALF + 9 * CLK_PER_BIT + SYNC_DLY;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       serial;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int   cyc;
  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];
  vec_t table_v[5];

  uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .serial    (serial),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic drive_bit(input logic b);
    serial = b;
    repeat (CLK_PER_BIT) @(posedge clk);
    #1;
  endtask

  // Called aligned 1ns after a posedge; consecutive calls give back-to-back frames
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    e.is_err = v.exp_err;
    e.data   = v.exp_data;
    e.due    = cyc + LATENCY;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(v.data[i]);
    drive_bit(v.stop);
  endtask

  task automatic wait_neg(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Scoreboard: every strobe must match the oldest expected frame
  always @(negedge clk) begin
    if (valid || frame_err) begin
      checkOutput("valid_ferr_exclusive", int'(valid & frame_err), 0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_strobe", {30'd0, valid, frame_err}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("strobe_kind", {30'd0, valid, frame_err}, e.is_err ? 1 : 2);
        checkOutput("strobe_data", int'(data), int'(e.data));
        checkOutput("strobe_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    serial   = 1'b1;
    rst_n    = 1'b0;

    table_v[0] = '{8'h63, 1'b1, 1'b0, 8'h63};
    table_v[1] = '{8'h00, 1'b1, 1'b0, 8'h00};
    table_v[2] = '{8'hFF, 1'b1, 1'b0, 8'hFF};
    table_v[3] = '{8'hA5, 1'b1, 1'b0, 8'hA5};
    table_v[4] = '{8'h5A, 1'b1, 1'b0, 8'h5A};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_data", int'(data), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_ferr", int'(frame_err), 0);
    checkOutput("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    $display("[TB] back-to-back table frames");
    for (int i = 0; i < 5; i++) applyStimulus(table_v[i]);

    $display("[TB] framing error then line held low");
    applyStimulus('{8'h3C, 1'b0, 1'b1, 8'h5A});
    repeat (300) @(posedge clk);
    @(negedge clk);
    checkOutput("break_busy_high", int'(busy), 1);
    serial = 1'b1;
    repeat (CLK_PER_BIT) @(posedge clk);
    @(negedge clk);
    checkOutput("break_exit_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    applyStimulus('{8'h81, 1'b1, 1'b0, 8'h81});

    $display("[TB] start glitch");
    begin
      int t0;
      t0 = cyc + 1 + SYNC_DLY;
      serial = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      serial = 1'b1;
      wait_neg(t0 + 5);
      checkOutput("glitch_busy_high", int'(busy), 1);
      wait_neg(t0 + 51);
      checkOutput("glitch_busy_low", int'(busy), 0);
      repeat (2000) @(posedge clk);
      #1;
    end

    $display("[TB] reset in the middle of 0x77");
    serial = 1'b0;
    repeat (CLK_PER_BIT) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) drive_bit(((8'h77 >> i) & 8'h01) != 0);
    serial = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_data", int'(data), 0);
    checkOutput("midreset_valid", int'(valid), 0);
    checkOutput("midreset_ferr", int'(frame_err), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (2 * CLK_PER_BIT) @(posedge clk);
    #1;
    applyStimulus('{8'h12, 1'b1, 1'b0, 8'h12});

    for (int i = 0; i < 4 * CLK_PER_BIT && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
